// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst sequencer: register map, SPICON bit
// positions, FSM state encoding and the SPICON word builder.
package spi_pkg;

  localparam logic [7:0] OFF_SPICON = 8'd0;
  localparam logic [7:0] OFF_CLKDIV = 8'd1;
  localparam logic [7:0] OFF_TX     = 8'd2;
  localparam logic [7:0] OFF_RX     = 8'd3;

  localparam int SPICON_BUSY = 0;
  localparam int SPICON_CPOL = 1;
  localparam int SPICON_CPHA = 2;
  localparam int SPICON_CONT = 3;
  localparam int SPICON_EN   = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_DIV,
    ST_LOAD_TX,
    ST_KICK,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RD_RX,
    ST_RX_OUT,
    ST_DONE,
    ST_ABORT
  } state_e;

  // cfg is packed {cont, cpha, cpol}; bits [7:5] of SPICON are always written 0.
  function automatic logic [7:0] spicon_word(input logic [2:0] cfg, input logic enable);
    logic [7:0] w;
    w = '0;
    w[SPICON_CPOL] = cfg[0];
    w[SPICON_CPHA] = cfg[1];
    w[SPICON_CONT] = cfg[2];
    w[SPICON_EN]   = enable;
    return w;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Burst request, TX/RX byte streams and SPI register-port master signals.
// The master modport is the sequencer's view; slave is the environment's.
interface spi_burst_ctrl_if;

  logic       start;
  logic [7:0] len;
  logic [2:0] cfg;
  logic [7:0] clkdiv;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rdata;

  modport master (
    input  start, len, cfg, clkdiv, tx_data, tx_valid, rx_ready, rdata,
    output tx_ready, rx_data, rx_valid, busy, done, err, addr, wdata, wr_en, rd_en
  );

  modport slave (
    output start, len, cfg, clkdiv, tx_data, tx_valid, rx_ready, rdata,
    input  tx_ready, rx_data, rx_valid, busy, done, err, addr, wdata, wr_en, rd_en
  );

endinterface

// File: rtl/spi_poll_timer.sv
// Saturating poll-cycle counter; expired once TIMEOUT cycles have been counted
// since the last clear.
module spi_poll_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer: per byte writes TX, kicks SPICON, polls the busy flag
// high then low, reads RX and hands it to the RX stream.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_burst_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [2:0] cfg_q, cfg_d;
  logic [7:0] clkdiv_q, clkdiv_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_first_q, rx_first_d;
  logic       poll_first_q, poll_first_d;

  logic poll_clear;
  logic poll_enable;
  logic poll_expired;

  assign poll_enable = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

  spi_poll_timer #(.TIMEOUT(TIMEOUT)) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (poll_clear),
    .enable  (poll_enable),
    .expired (poll_expired)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cfg_d        = cfg_q;
    clkdiv_d     = clkdiv_q;
    rx_data_d    = rx_data_q;
    rx_first_d   = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cfg_d       = bus.cfg;
          clkdiv_d    = bus.clkdiv;
          remaining_d = bus.len;
          state_d     = (bus.len == 8'd0) ? ST_DONE : ST_SET_DIV;
        end
      end
      ST_SET_DIV: begin
        bus.wr_en = 1'b1;
        bus.addr  = BASE_ADDR + OFF_CLKDIV;
        bus.wdata = clkdiv_q;
        state_d   = ST_LOAD_TX;
      end
      ST_LOAD_TX: begin
        bus.tx_ready = 1'b1;
        if (bus.tx_valid) begin
          bus.wr_en = 1'b1;
          bus.addr  = BASE_ADDR + OFF_TX;
          bus.wdata = bus.tx_data;
          state_d   = ST_KICK;
        end
      end
      ST_KICK: begin
        bus.wr_en = 1'b1;
        bus.addr  = BASE_ADDR + OFF_SPICON;
        bus.wdata = spicon_word(cfg_q, 1'b1);
        state_d   = ST_WAIT_HI;
      end
      // rdata in the first poll cycle belongs to the previous read, so skip it.
      ST_WAIT_HI: begin
        bus.rd_en = 1'b1;
        bus.addr  = BASE_ADDR + OFF_SPICON;
        if (!poll_first_q && bus.rdata[SPICON_BUSY]) begin
          state_d = ST_WAIT_LO;
        end else if (poll_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_WAIT_LO: begin
        bus.rd_en = 1'b1;
        bus.addr  = BASE_ADDR + OFF_SPICON;
        if (!poll_first_q && !bus.rdata[SPICON_BUSY]) begin
          state_d = ST_RD_RX;
        end else if (poll_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_RD_RX: begin
        bus.rd_en  = 1'b1;
        bus.addr   = BASE_ADDR + OFF_RX;
        rx_first_d = 1'b1;
        state_d    = ST_RX_OUT;
      end
      ST_RX_OUT: begin
        bus.rx_valid = 1'b1;
        if (rx_first_q) begin
          rx_data_d = bus.rdata;
        end
        if (bus.rx_ready) begin
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? ST_DONE : ST_LOAD_TX;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ABORT: begin
        bus.wr_en = 1'b1;
        bus.addr  = BASE_ADDR + OFF_SPICON;
        bus.wdata = spicon_word(cfg_q, 1'b0);
        bus.done  = 1'b1;
        bus.err   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    poll_clear = ((state_d == ST_WAIT_HI) && (state_q != ST_WAIT_HI)) ||
                 ((state_d == ST_WAIT_LO) && (state_q != ST_WAIT_LO));
    poll_first_d = poll_clear;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      cfg_q        <= '0;
      clkdiv_q     <= '0;
      rx_data_q    <= '0;
      rx_first_q   <= 1'b0;
      poll_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      cfg_q        <= cfg_d;
      clkdiv_q     <= clkdiv_d;
      rx_data_q    <= rx_data_d;
      rx_first_q   <= rx_first_d;
      poll_first_q <= poll_first_d;
    end
  end

  // RX data is only on the bus during the first RX_OUT cycle; hold it afterwards.
  assign bus.rx_data = rx_first_q ? bus.rdata : rx_data_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Randomized bench for spi_burst_ctrl with a behavioural SPI register-port
// model (RX = ~TX) and a scoreboard built from the burst rules.
module tb_spi_burst_ctrl;

  localparam logic [7:0] BASE = 8'h40;
  localparam int         TMO  = 32;

  logic clk = 1'b0;
  logic reset_n;

  spi_burst_ctrl_if bus();

  spi_burst_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Peripheral model: busy rises 2 cycles after an enable write, stays 16 cycles.
  bit   dead = 1'b0;
  int   per_timer = 0;
  logic [7:0] per_tx = 8'h00;
  logic per_busy;
  assign per_busy = (per_timer != 0) && (per_timer <= 16);

  always @(posedge clk) begin
    if (per_timer != 0) per_timer <= per_timer - 1;
    if (bus.wr_en) begin
      if (bus.addr == BASE && bus.wdata[4] && !dead) per_timer <= 18;
      if (bus.addr == BASE + 8'd2) per_tx <= bus.wdata;
    end
    if (bus.rd_en) bus.rdata <= (bus.addr == BASE + 8'd3) ? ~per_tx : {7'b0, per_busy};
  end

  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_wr[$];
  int   tx_idx = 0;
  bit   rand_hs = 1'b0;
  bit   stall_mode = 1'b0;
  logic [7:0] exp_kick = 8'h10;

  int both_cnt, any_bus, idle_junk, div_writes, kick_writes, kick_bad, clr_writes;
  int abort_with_done, other_wr, unstable, stall_seen, stall_bus, done_cnt;
  logic [7:0] last_div, last_clr, last_kick;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearScoreboard();
    rx_got.delete();
    tx_wr.delete();
    tx_idx = 0;
    both_cnt = 0; any_bus = 0; idle_junk = 0; div_writes = 0; kick_writes = 0;
    kick_bad = 0; clr_writes = 0; abort_with_done = 0; other_wr = 0; unstable = 0;
    stall_seen = 0; stall_bus = 0; done_cnt = 0;
    last_div = 8'h00; last_clr = 8'h00; last_kick = 8'h00;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    bit prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    clearScoreboard();
    forever begin
      @(negedge clk);
      if (bus.wr_en && bus.rd_en) both_cnt++;
      if (bus.wr_en || bus.rd_en) any_bus++;
      else if (bus.addr != 8'h00 || bus.wdata != 8'h00) idle_junk++;
      if (bus.wr_en) begin
        if (bus.addr == BASE + 8'd1) begin
          div_writes++;
          last_div = bus.wdata;
        end else if (bus.addr == BASE + 8'd2) begin
          tx_wr.push_back(bus.wdata);
        end else if (bus.addr == BASE) begin
          if (bus.wdata[4]) begin
            kick_writes++;
            last_kick = bus.wdata;
            if (bus.wdata != exp_kick) kick_bad++;
          end else begin
            clr_writes++;
            last_clr = bus.wdata;
            if (bus.done && bus.err) abort_with_done++;
          end
        end else begin
          other_wr++;
        end
      end
      if (prev_hold && (!bus.rx_valid || bus.rx_data != prev_data)) unstable++;
      prev_hold = bus.rx_valid && !bus.rx_ready;
      prev_data = bus.rx_data;
      if (stall_mode && bus.rx_valid && !bus.rx_ready && rx_got.size() == 1) begin
        stall_seen++;
        if (bus.wr_en || bus.rd_en) stall_bus++;
      end
      if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
      if (bus.done) done_cnt++;
    end
  end

  // TX source and RX sink drivers.
  initial begin
    bit tx_acc;
    forever begin
      @(negedge clk);
      tx_acc = bus.tx_valid && bus.tx_ready;
      @(posedge clk);
      #1;
      if (tx_acc) tx_idx++;
      if (tx_idx < tx_q.size()) begin
        bus.tx_valid = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.tx_data  = tx_q[tx_idx];
      end else begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
      end
      if (stall_mode && rx_got.size() == 1 && stall_seen < 10) bus.rx_ready = 1'b0;
      else bus.rx_ready = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic applyStimulus(input logic [7:0] n, input logic [2:0] c, input logic [7:0] div,
                               input bit is_dead, input bit do_restart, input bit do_stall,
                               input bit hs_rand);
    bit seen;
    logic [7:0] e;
    @(posedge clk);
    #3;
    clearScoreboard();
    dead = is_dead;
    stall_mode = do_stall;
    rand_hs = hs_rand;
    exp_kick = 8'h10 | {4'b0, c, 1'b0};
    bus.start = 1'b1;
    bus.len = n;
    bus.cfg = c;
    bus.clkdiv = div;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.len = 8'($urandom);
    bus.cfg = 3'($urandom);
    bus.clkdiv = 8'($urandom);
    @(negedge clk);
    checkOutput("busy_after_start", {31'b0, bus.busy}, 1);
    if (n == 8'd0) checkOutput("len0_done_latency", {31'b0, bus.done}, 1);
    else checkOutput("first_write_clkdiv", {15'b0, bus.wr_en, bus.addr, bus.wdata},
                     {15'b0, 1'b1, BASE + 8'd1, div});
    seen = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (bus.done) begin
        seen = 1'b1;
        checkOutput("done_err", {31'b0, bus.err}, {31'b0, is_dead});
      end else begin
        if (do_restart && cyc == 12) begin
          bus.start = 1'b1;
          bus.len = 8'd9;
          bus.cfg = ~c;
          bus.clkdiv = ~div;
        end
        if (do_restart && cyc == 13) bus.start = 1'b0;
        @(negedge clk);
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_done", {31'b0, bus.busy}, 0);
    checkOutput("done_one_cycle", {31'b0, bus.done}, 0);
    @(negedge clk);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("wr_rd_overlap", both_cnt, 0);
    checkOutput("idle_addr_wdata", idle_junk, 0);
    checkOutput("rx_stable", unstable, 0);
    checkOutput("stray_writes", other_wr, 0);
    if (is_dead) begin
      checkOutput("abort_clear_writes", clr_writes, 1);
      checkOutput("abort_clear_word", {24'b0, last_clr}, {24'b0, 5'b0, c, 1'b0});
      checkOutput("abort_with_done", abort_with_done, 1);
      checkOutput("abort_rx_count", rx_got.size(), 0);
      checkOutput("abort_kicks", kick_writes, 1);
    end else begin
      checkOutput("clear_writes", clr_writes, 0);
      checkOutput("rx_count", rx_got.size(), {24'b0, n});
      checkOutput("kick_count", kick_writes, {24'b0, n});
      checkOutput("kick_word", kick_bad, 0);
      checkOutput("clkdiv_writes", div_writes, (n != 8'd0) ? 1 : 0);
      if (n != 8'd0) checkOutput("clkdiv_value", {24'b0, last_div}, {24'b0, div});
      else checkOutput("len0_bus_quiet", any_bus, 0);
      checkOutput("tx_write_count", tx_wr.size(), {24'b0, n});
      for (int i = 0; i < tx_wr.size() && i < int'(n); i++)
        checkOutput($sformatf("tx_byte%0d", i), {24'b0, tx_wr[i]}, {24'b0, tx_q[i]});
      for (int i = 0; i < rx_got.size() && i < int'(n); i++) begin
        e = ~tx_q[i];
        checkOutput($sformatf("rx_byte%0d", i), {24'b0, rx_got[i]}, {24'b0, e});
      end
    end
    if (do_stall) begin
      checkOutput("stall_cycles", stall_seen, 10);
      checkOutput("stall_bus_quiet", stall_bus, 0);
    end
  endtask

  initial begin
    int busy_seen;
    int n;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.len = 8'h00; bus.cfg = 3'b000; bus.clkdiv = 8'h00;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {25'b0, bus.busy, bus.done, bus.err, bus.wr_en, bus.rd_en,
                               bus.tx_ready, bus.rx_valid}, 0);
    checkOutput("reset_data", {8'b0, bus.addr, bus.wdata, bus.rx_data}, 0);
    reset_n = 1'b1;

    $display("[TB] burst len=3 fixed bytes");
    tx_q = '{8'hA5, 8'h3C, 8'h00};
    applyStimulus(8'd3, 3'b000, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] zero-length burst");
    tx_q.delete();
    applyStimulus(8'd0, 3'b010, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] rx backpressure on byte 2 of 4");
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    applyStimulus(8'd4, 3'b001, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] cfg=101 with ignored restart");
    tx_q = '{8'h12, 8'h34, 8'h56};
    applyStimulus(8'd3, 3'b101, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("kick_word_cfg101", {24'b0, last_kick}, 32'h1A);

    $display("[TB] reset during WAIT_LO");
    tx_q = '{8'h11, 8'h22};
    @(posedge clk);
    #3;
    clearScoreboard();
    rand_hs = 1'b0; stall_mode = 1'b0; dead = 1'b0;
    bus.start = 1'b1; bus.len = 8'd2; bus.cfg = 3'b000; bus.clkdiv = 8'h03;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_seen = 0;
    for (int cyc = 0; cyc < 200 && busy_seen < 6; cyc++) begin
      @(negedge clk);
      if (per_busy) busy_seen++;
    end
    if (busy_seen < 6) checkOutput("reset_setup_timeout", 0, 1);
    checkOutput("pre_reset_rd_en", {31'b0, bus.rd_en}, 1);
    checkOutput("pre_reset_addr", {24'b0, bus.addr}, {24'b0, BASE});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", {25'b0, bus.busy, bus.done, bus.err, bus.wr_en, bus.rd_en,
                                  bus.tx_ready, bus.rx_valid}, 0);
    checkOutput("midreset_data", {8'b0, bus.addr, bus.wdata, bus.rx_data}, 0);
    any_bus = 0;
    repeat (2) @(negedge clk);
    checkOutput("midreset_bus_quiet", any_bus, 0);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    tx_q = '{8'h96};
    applyStimulus(8'd1, 3'b110, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 6);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      $display("[TB] random burst %0d len=%0d", k, n);
      applyStimulus(8'(n), 3'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("[TB] peripheral never busy, expect abort");
    tx_q = '{8'hF0, 8'h0F};
    applyStimulus(8'd2, 3'b011, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
